shot_ctrl: RTL and testbench

Projectile controller for the turret game. Sits directly downstream of the player position/aim stage: it samples the current `x_pos` and `aim_pos` when the fire button is pressed, then steps a single shot up the playfield, one row per frame tick. Its outputs feed the renderer and the collision logic. At most one shot is in flight at a time.

---
 rtl/shot_ctrl.sv | 141 ++++++++++++++
 tb/tb_shot_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shot_ctrl.sv
// shot_ctrl: single-shot projectile controller for the turret game.
// Latches the player column and aim on a fire edge, then steps the shot one
// row per frame tick until it reaches the last row (or a wall), followed by
// a cooldown period during which new fire presses are ignored.
// Build option: define SHOT_BOUNCE_EN to reflect the shot off the side
// walls instead of ending the flight there.
module shot_ctrl #(
    parameter int Y_MAX    = 23,
    parameter int COOLDOWN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       fire,
    input  logic [4:0] x_pos,
    input  logic [2:0] aim_pos,
    output logic [4:0] shot_x,
    output logic [4:0] shot_y,
    output logic       shot_active,
    output logic       shot_done,
    output logic       shot_wall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        COOL   = 2'd2
    } state_t;

    localparam logic [4:0] Y_LAST    = 5'(Y_MAX);
    localparam logic [3:0] COOL_INIT = 4'(COOLDOWN);

    state_t            state;
    logic              fire_q;
    logic signed [2:0] dx;
    logic        [3:0] cool_cnt;
    logic signed [6:0] nx;
    logic              x_in_range;
    logic              fire_edge;

    // Aim 0..6 maps to a column step of -3..+3; aim 7 saturates at +3.
    function automatic logic signed [2:0] aim_to_dx(input logic [2:0] aim);
        logic [2:0] diff;
        if (aim == 3'd7) begin
            return 3'sd3;
        end
        diff = aim - 3'd3;
        return $signed(diff);
    endfunction

`ifdef SHOT_BOUNCE_EN
    // Mirror an out-of-range column back into 0..31 about the crossed wall.
    function automatic logic [4:0] reflect_x(input logic signed [6:0] v);
        logic signed [6:0] r;
        if (v < 7'sd0) begin
            r = -v;
        end else if (v > 7'sd31) begin
            r = 7'sd62 - v;
        end else begin
            r = v;
        end
        return r[4:0];
    endfunction
`endif

    // Candidate next column, computed wide and signed so walls are visible.
    always_comb begin
        nx         = $signed({2'b00, shot_x}) + $signed({{4{dx[2]}}, dx});
        x_in_range = (nx >= 7'sd0) && (nx <= 7'sd31);
        fire_edge  = fire & ~fire_q;
    end

    // Shot state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fire_q      <= 1'b0;
            dx          <= 3'sd0;
            cool_cnt    <= 4'd0;
            shot_x      <= 5'd0;
            shot_y      <= 5'd0;
            shot_active <= 1'b0;
            shot_done   <= 1'b0;
            shot_wall   <= 1'b0;
        end else begin
            fire_q    <= fire;
            shot_done <= 1'b0;
            shot_wall <= 1'b0;
            case (state)
                IDLE: begin
                    // A tick arriving with the fire edge does not step the shot.
                    if (fire_edge) begin
                        shot_x      <= x_pos;
                        shot_y      <= 5'd0;
                        dx          <= aim_to_dx(aim_pos);
                        shot_active <= 1'b1;
                        state       <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (tick) begin
                        if (shot_y == Y_LAST) begin
                            // Last row takes priority over any wall on this tick.
                            shot_done   <= 1'b1;
                            shot_active <= 1'b0;
                            cool_cnt    <= COOL_INIT;
                            state       <= COOL;
                        end else if (x_in_range) begin
                            shot_y <= shot_y + 5'd1;
                            shot_x <= nx[4:0];
                        end else begin
`ifdef SHOT_BOUNCE_EN
                            shot_y <= shot_y + 5'd1;
                            shot_x <= reflect_x(nx);
                            dx     <= -dx;
`else
                            // Wall ends the flight; position holds where it was.
                            shot_done   <= 1'b1;
                            shot_wall   <= 1'b1;
                            shot_active <= 1'b0;
                            cool_cnt    <= COOL_INIT;
                            state       <= COOL;
`endif
                        end
                    end
                end
                COOL: begin
                    if (cool_cnt == 4'd0) begin
                        state <= IDLE;
                    end else if (tick) begin
                        cool_cnt <= cool_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_ctrl.sv
// tb_shot_ctrl: directed, table-driven bench for shot_ctrl (default
// parameters). Inputs change on the falling edge; outputs are compared on
// the following falling edge, half a cycle after the active edge.
module tb_shot_ctrl;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       fire;
    logic [4:0] x_pos;
    logic [2:0] aim_pos;
    logic [4:0] shot_x;
    logic [4:0] shot_y;
    logic       shot_active;
    logic       shot_done;
    logic       shot_wall;

    int checks   = 0;
    int failures = 0;

    shot_ctrl #(.Y_MAX(23), .COOLDOWN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .fire       (fire),
        .x_pos      (x_pos),
        .aim_pos    (aim_pos),
        .shot_x     (shot_x),
        .shot_y     (shot_y),
        .shot_active(shot_active),
        .shot_done  (shot_done),
        .shot_wall  (shot_wall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tk;
        logic       fr;
        logic [4:0] x;
        logic [2:0] a;
        logic [4:0] ex;
        logic [4:0] ey;
        logic       eact;
        logic       edone;
        logic       ewall;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input int t, input int f, input int x, input int a,
                                input int ex, input int ey, input int act,
                                input int done, input int wall);
        vec_t v;
        v.tk    = t[0];
        v.fr    = f[0];
        v.x     = x[4:0];
        v.a     = a[2:0];
        v.ex    = ex[4:0];
        v.ey    = ey[4:0];
        v.eact  = act[0];
        v.edone = done[0];
        v.ewall = wall[0];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int ex, input int ey,
                           input int act, input int done, input int wall);
        chk({name, ".shot_x"}, int'(shot_x), ex);
        chk({name, ".shot_y"}, int'(shot_y), ey);
        chk({name, ".shot_active"}, int'(shot_active), act);
        chk({name, ".shot_done"}, int'(shot_done), done);
        chk({name, ".shot_wall"}, int'(shot_wall), wall);
    endtask

    // Apply tick/fire for one cycle (tick is a single-cycle pulse), return on
    // the next falling edge with the results of that cycle visible.
    task automatic step(input logic t, input logic f);
        tick = t;
        fire = f;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Asynchronously pulse reset away from any clock edge.
    task automatic async_reset();
        #1 reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        tick    = 1'b0;
        fire    = 1'b0;
        x_pos   = 5'd0;
        aim_pos = 3'd0;

        vecs[0] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1] = mk(0, 1, 5, 6,  5, 0, 1, 0, 0);
        vecs[2] = mk(1, 1, 5, 6,  8, 1, 1, 0, 0);
        vecs[3] = mk(0, 0, 9, 1,  8, 1, 1, 0, 0);
        vecs[4] = mk(1, 1, 9, 1, 11, 2, 1, 0, 0);
        vecs[5] = mk(1, 0, 0, 0, 14, 3, 1, 0, 0);
        vecs[6] = mk(1, 0, 0, 0, 17, 4, 1, 0, 0);
        vecs[7] = mk(1, 0, 0, 0, 20, 5, 1, 0, 0);
        vecs[8] = mk(1, 0, 0, 0, 23, 6, 1, 0, 0);
        vecs[9] = mk(1, 0, 0, 0, 26, 7, 1, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;

        // Diagonal flight with ignored fire/aim changes mid-flight
        for (int i = 0; i < 10; i++) begin
            x_pos   = vecs[i].x;
            aim_pos = vecs[i].a;
            step(vecs[i].tk, vecs[i].fr);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey),
                    int'(vecs[i].eact), int'(vecs[i].edone), int'(vecs[i].ewall));
        end

        // Asynchronous reset mid-flight at shot_y = 7
        #2 reset = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic flight launched on a tick, fire held throughout
        x_pos   = 5'd10;
        aim_pos = 3'd3;
        step(1'b1, 1'b1);
        chk_all("launch_tick", 10, 0, 1, 0, 0);
        step(1'b1, 1'b1);
        chk("first_step.shot_y", int'(shot_y), 1);
        for (int i = 0; i < 22; i++) step(1'b1, 1'b1);
        chk_all("at_ymax", 10, 23, 1, 0, 0);
        step(1'b1, 1'b1);
        chk_all("end_tick", 10, 23, 0, 1, 0);
        step(1'b0, 1'b1);
        chk_all("done_once", 10, 23, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk_all("held_no_refire", 10, 23, 0, 0, 0);
        step(1'b0, 1'b0);

        // Aim 7 saturates to the same path as aim 6
        x_pos   = 5'd5;
        aim_pos = 3'd7;
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk_all("aim7_clamp", 14, 3, 1, 0, 0);
        async_reset();

        // Left wall hit
        x_pos   = 5'd1;
        aim_pos = 3'd0;
        step(1'b0, 1'b1);
        chk_all("wall_launch", 1, 0, 1, 0, 0);
        step(1'b1, 1'b1);
`ifdef SHOT_BOUNCE_EN
        chk_all("wall_bounce1", 2, 1, 1, 0, 0);
        step(1'b1, 1'b0);
        chk_all("wall_bounce2", 5, 2, 1, 0, 0);
        async_reset();
`else
        chk_all("wall_hit", 1, 0, 0, 1, 1);
        // Early press during cooldown is ignored, later press launches
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        x_pos   = 5'd20;
        aim_pos = 3'd3;
        step(1'b0, 1'b1);
        chk("early_press.shot_active", int'(shot_active), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("cool_exit.shot_active", int'(shot_active), 0);
        step(1'b0, 1'b1);
        chk_all("late_press", 20, 0, 1, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
